boot_stream_ctrl: RTL

BOOT_STREAM_CTRL -- requirements
Module: boot_stream_ctrl

---
 rtl/boot_stream_ctrl_if.sv | 28 ++
 rtl/boot_stream_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/boot_stream_ctrl_if.sv
// Host word-offer and loader byte-stream signals of the boot stream controller.
// slave is the controller's view; master is the host/loader view.
interface boot_stream_ctrl_if;
    logic [31:0] host_bootdata;
    logic        host_bootdata_req;
    logic        host_bootdata_ack;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;

    modport slave (
        input  host_bootdata,
        input  host_bootdata_req,
        input  byte_ready,
        output host_bootdata_ack,
        output byte_out,
        output byte_valid
    );

    modport master (
        output host_bootdata,
        output host_bootdata_req,
        output byte_ready,
        input  host_bootdata_ack,
        input  byte_out,
        input  byte_valid
    );
endinterface

// File: rtl/boot_stream_ctrl.sv
// Accepts boot words from the host, buffers them, and streams their bytes to the
// game loader starting at the first SYNC_BYTE, trimmed to rom_size bytes.
module boot_stream_ctrl #(
    parameter logic [7:0]  SYNC_BYTE = 8'h4E,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned FIFO_AW   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    boot_stream_ctrl_if.slave    bus,
    input  logic [31:0]          rom_size,
    output logic [31:0]          bytes_loaded,
    output logic                 sync_found,
    output logic                 done
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned EW    = 35;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACK     = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               ack_q, ack_d;
    logic [31:0]        bl_q, bl_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               full_q, full_d;
    logic [31:0]        sh_q, sh_d;
    logic [2:0]         rem_q, rem_d;
    logic               valid_q, valid_d;
    logic               sync_q, sync_d;
    logic               done_q, done_d;

    // Each entry carries the word plus how many of its bytes fall inside rom_size.
    logic [EW-1:0]      mem_q [DEPTH];

    logic               wr_en, pop, consume;
    logic [2:0]         wr_cnt, rem_left;
    logic [31:0]        remain, sh_shift;
    logic [EW-1:0]      rd_entry;
    logic [7:0]         head_d;

    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        bl_d     = bl_q;
        wr_en    = 1'b0;
        wr_cnt   = 3'd0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        sh_d     = sh_q;
        rem_d    = rem_q;
        pop      = 1'b0;
        remain   = rom_size - bl_q;
        rd_entry = mem_q[rd_ptr_q];

        // Host handshake: capture on IDLE->ACK, one ack per req assertion.
        case (state_q)
            S_IDLE: begin
                if (bus.host_bootdata_req && !full_q) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    if (bl_q < rom_size) begin
                        wr_en  = 1'b1;
                        wr_cnt = (remain > 32'd3) ? 3'd4 : 3'(remain);
                        bl_d   = bl_q + 32'(wr_cnt);
                    end
                end
            end
            S_ACK:     state_d = S_RELEASE;
            S_RELEASE: if (!bus.host_bootdata_req) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (wr_en) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);

        // Pre-sync bytes are dropped one per cycle; afterwards a byte leaves on ready.
        consume  = (rem_q != 3'd0) && (!valid_q || bus.byte_ready);
        rem_left = rem_q - 3'(consume);
        sh_shift = MSB_FIRST ? (sh_q << 8) : (sh_q >> 8);
        pop      = (rem_left == 3'd0) && (cnt_q != CW'(0));

        if (pop) begin
            sh_d     = rd_entry[31:0];
            rem_d    = rd_entry[34:32];
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end else if (consume) begin
            sh_d  = sh_shift;
            rem_d = rem_left;
        end

        cnt_d  = cnt_q + CW'(wr_en) - CW'(pop);
        full_d = (cnt_d == CW'(DEPTH));

        head_d  = MSB_FIRST ? sh_d[31:24] : sh_d[7:0];
        sync_d  = sync_q || ((rem_d != 3'd0) && (head_d == SYNC_BYTE));
        valid_d = (rem_d != 3'd0) && sync_d;
        done_d  = done_q || ((cnt_q == CW'(0)) && (rem_q == 3'd0) && (bl_q == rom_size));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ack_q    <= 1'b0;
            bl_q     <= 32'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            sh_q     <= 32'd0;
            rem_q    <= 3'd0;
            valid_q  <= 1'b0;
            sync_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            bl_q     <= bl_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            sh_q     <= sh_d;
            rem_q    <= rem_d;
            valid_q  <= valid_d;
            sync_q   <= sync_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {wr_cnt, bus.host_bootdata};
    end

    assign bus.host_bootdata_ack = ack_q;
    assign bus.byte_valid        = valid_q;
    assign bus.byte_out          = MSB_FIRST ? sh_q[31:24] : sh_q[7:0];
    assign bytes_loaded          = bl_q;
    assign sync_found            = sync_q;
    assign done                  = done_q;

endmodule
